// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame engine: FSM states, bin index
// reversal and a word-slice macro for NPTS*N packed frame buses.
`ifndef FFT_PKG_SV
`define FFT_PKG_SV

// Word j of a packed bus whose words are w bits wide.
`define FFT_WORD(bus, j, w) bus[(j)*(w) +: (w)]

package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_SERIAL  = 2'd2
  } fft_state_t;

  // Widest index supported (NPTS up to 256).
  localparam int unsigned FFT_MAX_LOGN = 8;

  // Reverse the low logn bits of k; upper bits of the result are zero.
  function automatic logic [FFT_MAX_LOGN-1:0] bitrev(
    input logic [FFT_MAX_LOGN-1:0] k,
    input int unsigned             logn
  );
    logic [FFT_MAX_LOGN-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < logn; b++) begin
      r[b] = k[logn-1-b];
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/fft_out_serializer.sv
// Output stage: captures the core result, then streams each bin as a
// real beat followed by an imaginary beat over a valid/ready handshake.
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int unsigned N    = 16,
  parameter int unsigned NPTS = 32,
  parameter int unsigned LOGN = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_capture,
  input  logic              i_bitrev,
  input  logic [NPTS*N-1:0] i_core_r,
  input  logic [NPTS*N-1:0] i_core_i,
  input  logic              i_out_ready,
  output logic              o_out_valid,
  output logic [N-1:0]      o_out_data,
  output logic              o_out_type,
  output logic [LOGN-1:0]   o_out_index,
  output logic              o_out_last,
  output logic              o_frame_done,
  output logic              o_final_hs
);

  // 2*NPTS-1 is all ones in LOGN+1 bits.
  localparam logic [LOGN:0] BEAT_LAST = '1;

  logic [N-1:0]    r_re [NPTS];
  logic [N-1:0]    r_im [NPTS];
  logic [LOGN:0]   r_bcnt;
  logic            r_valid;
  logic            r_done;
  logic [LOGN-1:0] w_k;
  logic [LOGN-1:0] w_idx;
  logic            w_hs;
  logic            w_last;

  assign w_k    = r_bcnt[LOGN:1];
  assign w_idx  = i_bitrev ? LOGN'(bitrev(FFT_MAX_LOGN'(w_k), LOGN)) : w_k;
  assign w_last = (r_bcnt == BEAT_LAST);
  assign w_hs   = r_valid & i_out_ready;

  assign o_out_valid  = r_valid;
  assign o_out_type   = r_bcnt[0];
  assign o_out_index  = w_idx;
  assign o_out_data   = r_bcnt[0] ? r_im[w_idx] : r_re[w_idx];
  assign o_out_last   = w_last;
  assign o_frame_done = r_done;
  assign o_final_hs   = w_hs & w_last;

  // Capture the result bins, then advance the beat counter on each handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned j = 0; j < NPTS; j++) begin
        r_re[j] <= '0;
        r_im[j] <= '0;
      end
      r_bcnt  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_hs & w_last;
      if (i_capture) begin
        for (int unsigned j = 0; j < NPTS; j++) begin
          r_re[j] <= `FFT_WORD(i_core_r, j, N);
          r_im[j] <= `FFT_WORD(i_core_i, j, N);
        end
        r_bcnt  <= '0;
        r_valid <= 1'b1;
      end else if (w_hs) begin
        if (w_last) begin
          r_bcnt  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fft_frame_stream.sv
// Handshaked frame engine around a parallel FFT core: double-buffered
// sample loading, hold register to the core, fixed-latency capture and
// serialised output of the complex bins.
module fft_frame_stream
  import fft_pkg::*;
#(
  parameter int unsigned N        = 16,
  parameter int unsigned Q        = 8,
  parameter int unsigned NPTS     = 32,
  parameter int unsigned LOGN     = 5,
  parameter int unsigned CORE_LAT = 0
) (
  input  logic              clk2,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_data,
  input  logic              mode_bitrev,
  output logic [NPTS*N-1:0] core_in_r,
  input  logic [NPTS*N-1:0] core_out_r,
  input  logic [NPTS*N-1:0] core_out_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_data,
  output logic              out_type,
  output logic [LOGN-1:0]   out_index,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done
);

  // Q only documents the fixed-point format of the data passing through.
  if (Q >= N) begin : g_q_wider_than_word
  end

  fft_state_t        r_state;
  fft_state_t        w_state_nxt;
  logic [N-1:0]      r_ld [NPTS];
  logic [LOGN-1:0]   r_wcnt;
  logic              r_ld_full;
  logic              r_in_ready;
  logic [NPTS*N-1:0] r_hold;
  logic              r_br_q;
  logic [3:0]        r_lat;
  logic              w_acc;
  logic              w_xfer;
  logic              w_capture;
  logic              w_final_hs;
  logic              w_ld_full_nxt;

  assign w_acc  = in_valid & r_in_ready;
  assign w_xfer = r_ld_full & ((r_state == ST_IDLE) | w_final_hs);
  assign w_ld_full_nxt = w_xfer ? 1'b0 : (r_ld_full | (w_acc & (r_wcnt == '1)));

  assign in_ready  = r_in_ready;
  assign core_in_r = r_hold;
  assign busy      = (r_state != ST_IDLE);

  // FSM state register.
  always_ff @(posedge clk2) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and capture strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    unique case (r_state)
      ST_IDLE:    if (w_xfer) w_state_nxt = ST_COMPUTE;
      ST_COMPUTE: if (r_lat == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_SERIAL;
                  end
      ST_SERIAL:  if (w_final_hs) w_state_nxt = w_xfer ? ST_COMPUTE : ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Load-side control: write pointer, full flag and registered ready.
  always_ff @(posedge clk2) begin
    if (rst) begin
      r_wcnt     <= '0;
      r_ld_full  <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_ld_full  <= w_ld_full_nxt;
      r_in_ready <= ~w_ld_full_nxt;
      if (w_xfer)     r_wcnt <= '0;
      else if (w_acc) r_wcnt <= r_wcnt + 1'b1;
    end
  end

  // Load buffer storage; stale contents are harmless since r_wcnt restarts at 0.
  always_ff @(posedge clk2) begin
    if (w_acc) r_ld[r_wcnt] <= in_data;
  end

  // Transfer: hold register, bit-reverse mode and core latency countdown.
  always_ff @(posedge clk2) begin
    if (rst) begin
      r_hold <= '0;
      r_br_q <= 1'b0;
      r_lat  <= '0;
    end else begin
      if (w_xfer) begin
        for (int unsigned j = 0; j < NPTS; j++) begin
          `FFT_WORD(r_hold, j, N) <= r_ld[j];
        end
        r_br_q <= mode_bitrev;
        r_lat  <= 4'(CORE_LAT);
      end else if ((r_state == ST_COMPUTE) && (r_lat != 4'd0)) begin
        r_lat <= r_lat - 1'b1;
      end
    end
  end

  fft_out_serializer #(
    .N    (N),
    .NPTS (NPTS),
    .LOGN (LOGN)
  ) u_ser (
    .i_clk        (clk2),
    .i_rst        (rst),
    .i_capture    (w_capture),
    .i_bitrev     (r_br_q),
    .i_core_r     (core_out_r),
    .i_core_i     (core_out_i),
    .i_out_ready  (out_ready),
    .o_out_valid  (out_valid),
    .o_out_data   (out_data),
    .o_out_type   (out_type),
    .o_out_index  (out_index),
    .o_out_last   (out_last),
    .o_frame_done (frame_done),
    .o_final_hs   (w_final_hs)
  );

endmodule

// File: tb/tb_fft_frame_stream.sv
// Bench for fft_frame_stream: three instances (32-pt latency 0, 32-pt
// latency 3, 8-pt 12-bit latency 1), one selected at a time, checked
// against a transaction-level model of frames, transfers and beats.
module tb_fft_frame_stream;

  logic        clk2 = 1'b0;
  logic        rst;
  logic        rst_q = 1'b1;
  logic        in_valid;
  logic [15:0] in_data;
  logic        mode_bitrev;
  logic        out_ready;
  int unsigned sel;
  int          core_mode;
  int          rdy_pct;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk2 = ~clk2;

  // per-instance nets
  logic         iv_a, ir_a, ov_a, ot_a, ol_a, bz_a, fd_a;
  logic         iv_b, ir_b, ov_b, ot_b, ol_b, bz_b, fd_b;
  logic         iv_c, ir_c, ov_c, ot_c, ol_c, bz_c, fd_c;
  logic [15:0]  od_a, od_b;
  logic [11:0]  od_c;
  logic [4:0]   oi_a, oi_b;
  logic [2:0]   oi_c;
  logic [511:0] cin_a, cor_a, coi_a, cin_b, cor_b, coi_b;
  logic [95:0]  cin_c, cor_c, coi_c;
  logic [511:0] cor_c_w, coi_c_w;

  // muxed view of the selected instance
  logic        m_in_ready, m_out_valid, m_out_type, m_out_last, m_busy, m_frame_done, m_cin_zero;
  logic [15:0] m_out_data;
  logic [4:0]  m_out_index;
  int          npts, logn, lat, wdt, wmask;

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // Stand-in core: 0 = DFT, 1 = ramp (j, -j), 2 = data-dependent scramble.
  function automatic int core_word(input int x[32], input int np, input int w,
                                   input int j, input bit im, input int mode);
    real acc, ang;
    int  xs;
    if (mode == 0) begin
      acc = 0.0;
      for (int n = 0; n < np; n++) begin
        xs  = (x[n] >= (1 << (w-1))) ? x[n] - (1 << w) : x[n];
        ang = 2.0 * 3.14159265358979 * real'(j * n) / real'(np);
        acc = im ? acc - real'(xs) * $sin(ang) : acc + real'(xs) * $cos(ang);
      end
      return rnd(acc);
    end else if (mode == 1) begin
      return im ? -j : j;
    end
    return im ? x[np-1-j] + 3*j : x[j] ^ 'h0A5;
  endfunction

  function automatic logic [511:0] core_bus(input logic [511:0] bus, input int np, input int w,
                                            input bit im, input int mode);
    int x[32];
    int m;
    logic [511:0] r;
    m = (1 << w) - 1;
    r = '0;
    for (int j = 0; j < 32; j++) x[j] = (j < np) ? (int'(bus >> (j*w)) & m) : 0;
    for (int j = 0; j < np; j++) r = r | (512'(core_word(x, np, w, j, im, mode) & m) << (j*w));
    return r;
  endfunction

  function automatic int brev(input int k, input int lg);
    int r = 0;
    for (int i = 0; i < lg; i++) if (((k >> i) & 1) != 0) r |= 1 << (lg-1-i);
    return r;
  endfunction

  assign cor_a   = core_bus(cin_a, 32, 16, 1'b0, core_mode);
  assign coi_a   = core_bus(cin_a, 32, 16, 1'b1, core_mode);
  assign cor_b   = core_bus(cin_b, 32, 16, 1'b0, core_mode);
  assign coi_b   = core_bus(cin_b, 32, 16, 1'b1, core_mode);
  assign cor_c_w = core_bus(512'(cin_c), 8, 12, 1'b0, core_mode);
  assign coi_c_w = core_bus(512'(cin_c), 8, 12, 1'b1, core_mode);
  assign cor_c   = cor_c_w[95:0];
  assign coi_c   = coi_c_w[95:0];

  assign iv_a = in_valid && (sel == 0);
  assign iv_b = in_valid && (sel == 1);
  assign iv_c = in_valid && (sel == 2);

  always_comb begin
    case (sel)
      0: begin
        m_in_ready = ir_a; m_out_valid = ov_a; m_out_type = ot_a; m_out_last = ol_a;
        m_busy = bz_a; m_frame_done = fd_a; m_out_data = od_a; m_out_index = oi_a;
        m_cin_zero = (cin_a == '0); npts = 32; logn = 5; lat = 0; wdt = 16;
      end
      1: begin
        m_in_ready = ir_b; m_out_valid = ov_b; m_out_type = ot_b; m_out_last = ol_b;
        m_busy = bz_b; m_frame_done = fd_b; m_out_data = od_b; m_out_index = oi_b;
        m_cin_zero = (cin_b == '0); npts = 32; logn = 5; lat = 3; wdt = 16;
      end
      default: begin
        m_in_ready = ir_c; m_out_valid = ov_c; m_out_type = ot_c; m_out_last = ol_c;
        m_busy = bz_c; m_frame_done = fd_c; m_out_data = {4'd0, od_c}; m_out_index = {2'd0, oi_c};
        m_cin_zero = (cin_c == '0); npts = 8; logn = 3; lat = 1; wdt = 12;
      end
    endcase
    wmask = (1 << wdt) - 1;
  end

  fft_frame_stream #(.N(16), .Q(8), .NPTS(32), .LOGN(5), .CORE_LAT(0)) u_dut_a (
    .clk2(clk2), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .in_data(in_data),
    .mode_bitrev(mode_bitrev), .core_in_r(cin_a), .core_out_r(cor_a), .core_out_i(coi_a),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_type(ot_a),
    .out_index(oi_a), .out_last(ol_a), .busy(bz_a), .frame_done(fd_a));

  fft_frame_stream #(.N(16), .Q(8), .NPTS(32), .LOGN(5), .CORE_LAT(3)) u_dut_b (
    .clk2(clk2), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .in_data(in_data),
    .mode_bitrev(mode_bitrev), .core_in_r(cin_b), .core_out_r(cor_b), .core_out_i(coi_b),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_type(ot_b),
    .out_index(oi_b), .out_last(ol_b), .busy(bz_b), .frame_done(fd_b));

  fft_frame_stream #(.N(12), .Q(8), .NPTS(8), .LOGN(3), .CORE_LAT(1)) u_dut_c (
    .clk2(clk2), .rst(rst), .in_valid(iv_c), .in_ready(ir_c), .in_data(in_data[11:0]),
    .mode_bitrev(mode_bitrev), .core_in_r(cin_c), .core_out_r(cor_c), .core_out_i(coi_c),
    .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c), .out_type(ot_c),
    .out_index(oi_c), .out_last(ol_c), .busy(bz_c), .frame_done(fd_c));

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int pending, cd, b, frames_done, acc_busy;
  bit eng_busy, serial, fd_exp, br_l;
  int fr[32];
  int ex_re[32], ex_im[32];
  int obs_d[64], obs_i[64];

  always @(posedge clk2) rst_q <= rst;

  always @(negedge clk2) begin : model
    int  k, idx, d;
    bit  acc, hs, fin, xfer;
    if (rst_q) begin
      chk_eq("rst_in_ready", m_in_ready, 0);
      chk_eq("rst_out_valid", m_out_valid, 0);
      chk_eq("rst_out_last", m_out_last, 0);
      chk_eq("rst_frame_done", m_frame_done, 0);
      chk_eq("rst_busy", m_busy, 0);
      chk_eq("rst_out_data", m_out_data, 0);
      chk_eq("rst_out_index", m_out_index, 0);
      chk_eq("rst_out_type", m_out_type, 0);
      chk_eq("rst_core_in_zero", m_cin_zero, 1);
      pending = 0; eng_busy = 0; serial = 0; fd_exp = 0; cd = -1; b = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin serial = 1; b = 0; cd = -1; end
      end
      chk_eq("in_ready", m_in_ready, pending < npts);
      chk_eq("busy", m_busy, eng_busy);
      chk_eq("out_valid", m_out_valid, serial);
      chk_eq("frame_done", m_frame_done, fd_exp);
      if (serial) begin
        k   = b / 2;
        idx = br_l ? brev(k, logn) : k;
        d   = (b % 2 != 0) ? ex_im[idx] : ex_re[idx];
        chk_eq("out_data", m_out_data, d);
        chk_eq("out_index", m_out_index, idx);
        chk_eq("out_type", m_out_type, b % 2);
        chk_eq("out_last", m_out_last, b == 2*npts-1);
      end
      acc  = in_valid && m_in_ready;
      hs   = serial && out_ready;
      fin  = hs && (b == 2*npts-1);
      xfer = (pending == npts) && (!eng_busy || fin);
      fd_exp = fin;
      if (hs) begin
        obs_d[b] = int'(m_out_data);
        obs_i[b] = int'(m_out_index);
        if (fin) begin
          serial = 0; b = 0; frames_done++;
          if (!xfer) eng_busy = 0;
        end else b++;
      end
      if (xfer) begin
        for (int j = 0; j < npts; j++) begin
          ex_re[j] = core_word(fr, npts, wdt, j, 1'b0, core_mode) & wmask;
          ex_im[j] = core_word(fr, npts, wdt, j, 1'b1, core_mode) & wmask;
        end
        br_l = mode_bitrev; pending = 0; eng_busy = 1; cd = lat + 2;
      end
      if (acc) begin
        fr[pending] = int'(in_data) & wmask;
        pending++;
        if (eng_busy) acc_busy++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk2); #1;
      out_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  task automatic do_reset(input int unsigned new_sel);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk2); #1 sel = new_sel;
    repeat (2) @(posedge clk2);
    #1 rst = 1'b0;
  endtask

  task automatic send_sample(input int v, input int pct);
    logic r;
    while ($urandom_range(99) >= pct) begin
      in_valid = 1'b0; @(posedge clk2); #1;
    end
    in_valid = 1'b1; in_data = 16'(v);
    for (int t = 0; ; t++) begin
      @(negedge clk2); r = m_in_ready;
      @(posedge clk2); #1;
      if (r) break;
      if (t > 3000) begin chk_eq("in_accept_timeout", 0, 1); break; end
    end
    in_valid = 1'b0;
  endtask

  // kind 0: impulse of 0x0100 at sample 0; kind 1: random words
  task automatic send_frame(input int kind, input int pct);
    for (int i = 0; i < npts; i++)
      send_sample((kind == 0) ? ((i == 0) ? 'h0100 : 0) : int'($urandom) & wmask, pct);
  endtask

  task automatic wait_frames(input int target);
    int t;
    for (t = 0; t < 20000; t++) begin
      if (frames_done >= target && !eng_busy) break;
      @(posedge clk2);
    end
    if (t >= 20000) chk_eq("frame_timeout", frames_done, target);
    repeat (2) @(posedge clk2);
    #1;
  endtask

  int base;
  int br_tab[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode_bitrev = 1'b0;
    core_mode = 0; rdy_pct = 100; sel = 0; frames_done = 0; acc_busy = 0;
    repeat (3) @(posedge clk2);
    #1 rst = 1'b0;

    // impulse through DFT core, natural order
    base = frames_done;
    send_frame(0, 100);
    wait_frames(base + 1);
    for (int i = 0; i < 64; i++)
      chk_eq("impulse_beat", obs_d[i], (i % 2 == 0) ? 'h0100 : 0);

    // ramp core, bit-reversed order
    core_mode = 1; mode_bitrev = 1'b1; base = frames_done;
    send_frame(1, 100);
    wait_frames(base + 1);
    chk_eq("br_b2_index", obs_i[2], 16);
    chk_eq("br_b2_data", obs_d[2], 16);
    chk_eq("br_b3_data", obs_d[3], 'hFFF0);

    // random data under 30% output readiness
    core_mode = 2; mode_bitrev = 1'($urandom); rdy_pct = 30; base = frames_done;
    send_frame(1, 80);
    wait_frames(base + 1);

    // back-to-back frames with latency 3
    do_reset(1);
    rdy_pct = 100; mode_bitrev = 1'b0; acc_busy = 0; base = frames_done;
    send_frame(1, 100);
    send_frame(1, 100);
    wait_frames(base + 2);
    chk_eq("b2b_load_overlap", acc_busy > 0, 1);

    // reset mid-load, then a clean frame
    for (int i = 0; i < 10; i++) send_sample(int'($urandom) & wmask, 100);
    do_reset(1);
    rdy_pct = 70; base = frames_done;
    send_frame(1, 90);
    wait_frames(base + 1);

    // 8-point, 12-bit instance: bit-reversed then natural
    do_reset(2);
    mode_bitrev = 1'b1; base = frames_done;
    send_frame(1, 90);
    wait_frames(base + 1);
    for (int k = 0; k < 8; k++) chk_eq("p8_br_index", obs_i[2*k], br_tab[k]);
    mode_bitrev = 1'b0; rdy_pct = 100; base = frames_done;
    send_frame(1, 100);
    wait_frames(base + 1);
    for (int k = 0; k < 8; k++) chk_eq("p8_nat_index", obs_i[2*k+1], k);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
